// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with boot, run, post-branch flush
// and halt states. Owns the 12-bit PC and presents it as a 16-bit fetch address.
//
// Optional feature: define PC_BRANCH_COUNT_EN to build a saturating counter of
// accepted branch redirects on branch_count. Without it the port is tied to
// zero and no counter flops exist.
module pc_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        is_cmpb_satisfied,
  input  logic [11:0] cmpb_address,
  input  logic        halt,
  input  logic        resume,
  output logic [15:0] instr_address,
  output logic        fetch_valid,
  output logic        flush,
  output logic        halted,
  output logic [15:0] branch_count
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic        redirect;

  // Next-state and next-PC selection; branch has priority over halt in RUN.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    redirect = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          if (is_cmpb_satisfied) begin
            pc_d     = cmpb_address;
            state_d  = ST_FLUSH;
            redirect = 1'b1;
          end else if (halt) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + 12'd1;  // natural 12-bit wrap FFF -> 000
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      ST_HALT: begin
        if (resume) begin
          pc_d    = pc_q + 12'd1;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State and PC registers; reset abandons any flush or halt in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= 12'h000;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_BRANCH_COUNT_EN
  logic [15:0] branch_count_q;

  // Count accepted redirects, holding at all-ones once full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_q <= 16'h0000;
    end else if (redirect && (branch_count_q != 16'hFFFF)) begin
      branch_count_q <= branch_count_q + 16'd1;
    end
  end

  assign branch_count = branch_count_q;
`else
  logic unused_redirect;
  assign unused_redirect = redirect;
  assign branch_count    = 16'h0000;
`endif

  // Outputs decode purely from state and PC.
  assign instr_address = {4'b0000, pc_q};
  assign fetch_valid   = (state_q == ST_RUN);
  assign flush         = (state_q == ST_FLUSH);
  assign halted        = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed stimulus, a behavioural model checked on
// every falling edge, plus literal expectations at key points.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        is_cmpb_satisfied;
  logic [11:0] cmpb_address;
  logic        halt;
  logic        resume;
  logic [15:0] instr_address;
  logic        fetch_valid;
  logic        flush;
  logic        halted;
  logic [15:0] branch_count;

  int tests = 0;
  int fails = 0;

  pc_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall             (stall),
    .is_cmpb_satisfied (is_cmpb_satisfied),
    .cmpb_address      (cmpb_address),
    .halt              (halt),
    .resume            (resume),
    .instr_address     (instr_address),
    .fetch_valid       (fetch_valid),
    .flush             (flush),
    .halted            (halted),
    .branch_count      (branch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef enum {M_BOOT, M_RUN, M_FLUSH, M_HALT} mode_t;
  mode_t m_mode;
  int    m_pc;        // 0..4095
  int    m_branches;  // accepted redirects since reset

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode     <= M_BOOT;
      m_pc       <= 0;
      m_branches <= 0;
    end else begin
      case (m_mode)
        M_BOOT:  m_mode <= M_RUN;
        M_FLUSH: m_mode <= M_RUN;
        M_RUN: begin
          if (!stall) begin
            if (is_cmpb_satisfied) begin
              m_pc       <= int'(cmpb_address);
              m_mode     <= M_FLUSH;
              m_branches <= m_branches + 1;
            end else if (halt) begin
              m_mode <= M_HALT;
            end else begin
              m_pc <= (m_pc + 1) % 4096;
            end
          end
        end
        M_HALT: begin
          if (resume) begin
            m_pc   <= (m_pc + 1) % 4096;
            m_mode <= M_RUN;
          end
        end
        default: m_mode <= M_BOOT;
      endcase
    end
  end

  function automatic int exp_count();
`ifdef PC_BRANCH_COUNT_EN
    return (m_branches > 65535) ? 65535 : m_branches;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: outputs against the model, away from the active edge.
  always @(negedge clk) begin
    check("m_addr",   int'(instr_address), m_pc);
    check("m_fvalid", int'(fetch_valid),   (m_mode == M_RUN)   ? 1 : 0);
    check("m_flush",  int'(flush),         (m_mode == M_FLUSH) ? 1 : 0);
    check("m_halted", int'(halted),        (m_mode == M_HALT)  ? 1 : 0);
    check("m_bcount", int'(branch_count),  exp_count());
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic s, input logic b, input logic [11:0] a,
                        input logic h, input logic r);
    stall             = s;
    is_cmpb_satisfied = b;
    cmpb_address      = a;
    halt              = h;
    resume            = r;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
  endtask

  // Branch to target and land in RUN there (two cycles).
  task automatic go_to(input logic [11:0] target);
    set_in(1'b0, 1'b1, target, 1'b0, 1'b0);
    tick();
    idle();
    tick();
  endtask

  task automatic expect_out(input string name, input int addr, input int fv,
                            input int fl, input int hl);
    check({name, "_addr"},   int'(instr_address), addr);
    check({name, "_fvalid"}, int'(fetch_valid),   fv);
    check({name, "_flush"},  int'(flush),         fl);
    check({name, "_halted"}, int'(halted),        hl);
  endtask

  int bc_before;

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    expect_out("reset", 16'h0000, 0, 0, 0);
    check("reset_bcount", int'(branch_count), 0);

    // Release: BOOT, then sequential fetch from zero.
    rst_n = 1'b1;
    expect_out("boot", 16'h0000, 0, 0, 0);
    tick(); expect_out("seq0", 16'h0000, 1, 0, 0);
    tick(); expect_out("seq1", 16'h0001, 1, 0, 0);
    tick(); expect_out("seq2", 16'h0002, 1, 0, 0);
    tick(); expect_out("seq3", 16'h0003, 1, 0, 0);

    // Walk up to 0x010, then branch to 0x0F8.
    repeat (13) tick();
    expect_out("at010", 16'h0010, 1, 0, 0);
    bc_before = int'(branch_count);
    set_in(1'b0, 1'b1, 12'h0F8, 1'b0, 1'b0);
    tick(); expect_out("br_flush", 16'h00F8, 0, 1, 0);
`ifdef PC_BRANCH_COUNT_EN
    check("br_count", int'(branch_count), bc_before + 1);
`else
    check("br_count", int'(branch_count), 0);
`endif
    // Stall and halt during FLUSH are ignored.
    set_in(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
    tick(); expect_out("br_land", 16'h00F8, 1, 0, 0);
    idle();

    // PC wrap FFF -> 000.
    go_to(12'hFFF);
    expect_out("at_fff", 16'h0FFF, 1, 0, 0);
    tick(); expect_out("wrap", 16'h0000, 1, 0, 0);

    // Branch and halt together: branch wins.
    go_to(12'h020);
    set_in(1'b0, 1'b1, 12'h030, 1'b1, 1'b0);
    tick(); expect_out("bh_flush", 16'h0030, 0, 1, 0);
    set_in(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    tick(); expect_out("bh_land", 16'h0030, 1, 0, 0);
    idle();

    // Halt at 0x040, hold for 10 cycles despite noise, then resume.
    go_to(12'h040);
    set_in(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    tick(); expect_out("halt0", 16'h0040, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      set_in(i[0], i[1], 12'h123, i[2], 1'b0);
      tick();
    end
    expect_out("halt10", 16'h0040, 0, 0, 1);
    set_in(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    tick(); expect_out("resume", 16'h0041, 1, 0, 0);
    idle();

    // Stall masks a pending branch; release accepts it.
    go_to(12'h050);
    set_in(1'b1, 1'b1, 12'h077, 1'b1, 1'b0);
    repeat (3) tick();
    expect_out("stall3", 16'h0050, 1, 0, 0);
    set_in(1'b0, 1'b1, 12'h077, 1'b0, 1'b0);
    tick(); expect_out("unstall", 16'h0077, 0, 1, 0);
    idle();
    tick(); expect_out("unstall_land", 16'h0077, 1, 0, 0);

    // Reset mid-FLUSH: no redirect survives.
    set_in(1'b0, 1'b1, 12'h3AB, 1'b0, 1'b0);
    tick(); expect_out("pre_rst_flush", 16'h03AB, 0, 1, 0);
    idle();
    rst_n = 1'b0;
    #1;
    expect_out("rst_flush", 16'h0000, 0, 0, 0);
    check("rst_flush_bcount", int'(branch_count), 0);
    tick();
    rst_n = 1'b1;
    tick(); expect_out("rst_flush_run", 16'h0000, 1, 0, 0);
    tick(); expect_out("rst_flush_seq", 16'h0001, 1, 0, 0);

    // Reset mid-HALT.
    go_to(12'h200);
    set_in(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    tick(); expect_out("pre_rst_halt", 16'h0200, 0, 0, 1);
    idle();
    rst_n = 1'b0;
    #1;
    expect_out("rst_halt", 16'h0000, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    expect_out("rst_halt_boot", 16'h0000, 0, 0, 0);
    tick(); expect_out("rst_halt_run", 16'h0000, 1, 0, 0);

    repeat (2) tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 stall  input  1  downstream hold; PC and state frozen while high.
REQ-005 is_cmpb_satisfied  input  1  compare-branch taken, from the branch checker.
REQ-006 cmpb_address  input  12  branch target, valid when is_cmpb_satisfied=1.
REQ-007 halt  input  1  decoded halt instruction at current PC.
REQ-008 resume  input  1  single-cycle pulse leaving HALT.
REQ-009 instr_address  output  16  fetch address = {4'b0000, pc}.
REQ-010 fetch_valid  output  1  instr_address is a live fetch this cycle.
REQ-011 flush  output  1  decode SHALL discard its instruction this cycle.
REQ-012 halted  output  1  high while in HALT.
REQ-013 branch_count  output  16  taken-redirect counter (see Configuration).

Function
REQ-014 States SHALL be BOOT, RUN, FLUSH, HALT; all outputs registered or decoded from state and pc only.
REQ-015 BOOT: fetch_valid=0, flush=0; next cycle unconditionally RUN, pc unchanged.
REQ-016 RUN, stall=0, is_cmpb_satisfied=1: pc<=cmpb_address, next state FLUSH.
REQ-017 RUN, stall=0, is_cmpb_satisfied=0, halt=1: pc held, next state HALT.
REQ-018 RUN, stall=0, neither: pc<=pc+1, 12-bit wrap 12'hFFF->12'h000.
REQ-019 Branch and halt in same cycle: branch SHALL win; halt ignored.
REQ-020 RUN, stall=1: pc and state held; is_cmpb_satisfied and halt ignored; fetch_valid stays 1.
REQ-021 FLUSH: fetch_valid=0, flush=1, pc held at target; next state RUN regardless of stall, branch or halt.
REQ-022 Branch latency: branch accepted at cycle n -> FLUSH at n+1 -> target fetched (fetch_valid=1) at n+2.
REQ-023 HALT: fetch_valid=0, halted=1, pc held; resume=1 -> pc<=pc+1, RUN; all other inputs ignored.
REQ-024 fetch_valid=1 only in RUN; flush=1 only in FLUSH; halted=1 only in HALT.
REQ-025 instr_address[15:12] SHALL always read 4'b0000.

Reset
REQ-026 rst_n low SHALL immediately force pc=12'h000, state=BOOT, fetch_valid=0, flush=0, halted=0, branch_count=16'h0000.
REQ-027 Reset asserted mid-FLUSH or mid-HALT SHALL abandon that state with no pending redirect retained.
REQ-028 First fetch after rst_n release SHALL be address 16'h0000 on the second rising edge.

Configuration
REQ-029 Macro PC_BRANCH_COUNT_EN: when defined, branch_count SHALL increment by 1 on every accepted redirect (REQ-016), saturating at 16'hFFFF.
REQ-030 Without PC_BRANCH_COUNT_EN the port SHALL remain and be driven constant 16'h0000; no counter flops.

Verification
REQ-031 Reset release, no branches, 5 cycles -> instr_address 0000 (BOOT, fetch_valid=0), then 0000,0001,0002,0003 with fetch_valid=1.
REQ-032 pc=0x010, is_cmpb_satisfied=1, cmpb_address=0x0F8 -> next cycle flush=1, fetch_valid=0, address 0x00F8; following cycle fetch_valid=1 at 0x00F8; branch_count=1 (macro on).
REQ-033 pc=0xFFF, RUN, no stall -> next address 0x0000, fetch_valid=1.
REQ-034 pc=0x020, halt=1 and is_cmpb_satisfied=1 (target 0x030) same cycle -> FLUSH then fetch 0x0030; halted never asserted.
REQ-035 pc=0x040, halt=1 -> halted=1, fetch_valid=0 held 10 cycles; resume pulse -> RUN at 0x0041.
REQ-036 stall=1 for 3 cycles with is_cmpb_satisfied=1 at pc=0x050 -> pc stays 0x050, no flush; stall low -> redirect accepted.
